csidh_ise_ctrl: RTL and testbench
=================================

Name: csidh_ise_ctrl

Overview:
- Issue/response controller that sequences the combinational CSIDH custom-0 datapath (andadd/sub) for the rv64 core.
- Registers each request, decodes it and drives the datapath from that register.
- Buffers results in a small FIFO so the core can stall writeback.
- Illegal encodings always complete, with an error flag, so the core never hangs.

Parameters:
ISE_V, 2'b11, feature mask; bit 1 enables the CSIDH ops, and when 0 every op is illegal.
DEPTH, 2, result FIFO entries (power of two, ≥2).

Ports:
ise_clk  in  1  clock
ise_rst  in  1  reset; asynchronous, active-low
ise_flush  in  1  synchronous kill of all in-flight ops
ise_val  in  1  request valid
ise_rdy  out  1  request ready
ise_fn  in  6  custom opcode select; [1:0]==2'b00 is CUSTOM_0
ise_imm  in  7  funct field; [3:0] op, [6:4] shift/mask immediate
ise_in1  in  64  rs1
ise_in2  in  64  rs2
ise_oval  out  1  result valid
ise_ordy  in  1  core accepts result
ise_out  out  64  result
ise_err  out  1  result belongs to an illegal op
ise_busy  out  1  op in S1 or in the FIFO
dp_in1  out  64  datapath rs1
dp_in2  out  64  datapath rs2
dp_imm  out  3  datapath imm
dp_op_andadd  out  1  datapath select
dp_op_sub  out  1  datapath select
dp_rd  in  64  datapath result (combinational from the dp_* outputs)

Behaviour:
- Reset (ise_rst=0, asynchronous):
  - S1 and the FIFO become empty; pointers and count go to 0.
  - Outputs: ise_oval=0, ise_out=0, ise_err=0, ise_busy=0, all dp_* = 0.
  - ise_rdy=0 while in reset, 1 on the first cycle after release.
- Reset mid-operation discards everything; no result is produced for an op already accepted.
- S1 issue register:
  - Loads fn, imm, in1, in2 on ise_val && ise_rdy.
  - ise_rdy = !ise_flush && (!s1_v || s1_adv).
  - s1_adv = s1_v && (!full || pop).
- Decode, from the S1 register:
  - andadd = ISE_V[1] && fn[1:0]==2'b00 && imm[3:0]==4'b0111.
  - sub = ISE_V[1] && fn[1:0]==2'b00 && imm[3:0]==4'b0011.
  - legal = andadd || sub.
- Datapath drive:
  - dp_in1, dp_in2, dp_imm = S1 in1, in2, imm[6:4] only when s1_v && legal; otherwise all zero.
  - dp_op_andadd and dp_op_sub follow the same gating; at most one is ever high.
- FIFO push:
  - Occurs on s1_adv. Entry = {legal ? dp_rd : 64'd0, !legal}.
  - Full with a same-cycle pop is allowed: count stays the same and both pointers advance.
- FIFO pop:
  - pop = ise_oval && ise_ordy.
  - ise_oval = count!=0.
  - ise_out and ise_err come from the head entry; both are zero when empty.
- Pointers: log2(DEPTH) bits, wrap modulo DEPTH. Count: 0..DEPTH.
- Latency and throughput:
  - Handshake in cycle t gives ise_oval in cycle t+2.
  - Sustained rate is 1 op/cycle when ise_ordy=1.
- Backpressure:
  - FIFO full and no pop means S1 holds and ise_rdy=0.
  - Maximum in flight = DEPTH+1.
- Flush:
  - ise_flush=1 clears S1 and the FIFO at the clock edge.
  - Overrides any push, pop or accept in that cycle. ise_rdy=0 that cycle.
  - ise_oval falls the cycle after.
- Ordering: results return in issue order.
- Busy: ise_busy = s1_v || count!=0 (registered state only).

Decomposition:
- Shared package csidh_ise_pkg holds:
  - CUSTOM_0..CUSTOM_3 (2-bit).
  - FUNCT_ANDADD=4'b0111 and FUNCT_SUB=4'b0011.
  - XLEN=64.
- One natural sub-module: csidh_ise_rfifo, a DEPTH-entry synchronous FIFO of {err, data} with flush input.
- The datapath stays external, connected through the dp_* ports.
- Integration wraps this controller together with the existing datapath.

Test Plan:
- Single op, with the bench model dp_rd = dp_in1 ^ dp_in2:
  - Stimulus: fn=6'h00, imm=7'b0010111, in1=64'hF0, in2=64'h0F, ordy=1.
  - Response: dp_op_andadd=1 and dp_imm=3'b001 in t+1; ise_oval=1, ise_out=64'hFF, ise_err=0 in t+2.
- Back-to-back throughput:
  - Stimulus: 8 consecutive sub ops (imm[3:0]=0011), ordy=1.
  - Response: ise_rdy stays 1; 8 results on consecutive cycles starting at t+2, in order.
- Backpressure (DEPTH=2):
  - Stimulus: ordy=0 and 4 requests offered.
  - Response: 3 accepted, then ise_rdy=0. Raising ordy drains 3 results in order and ise_rdy returns to 1.
- Illegal op:
  - Stimulus: fn=6'h01, imm=7'b0000111.
  - Response: all dp_* = 0; result ise_out=0, ise_err=1 at t+2.
- Flush and reset:
  - Stimulus: flush with the FIFO full and S1 valid.
  - Response: ise_oval=0 and ise_busy=0 the next cycle; no stale results appear afterwards.
  - Stimulus: ise_rst asserted mid-stream.
  - Response: all outputs 0 immediately (asynchronous); the first op after release has latency 2.

Source files
------------

// File: rtl/csidh_ise_pkg.sv
// Shared encodings and types for the CSIDH custom-0 issue/response controller.
package csidh_ise_pkg;
  localparam int XLEN = 64;

  localparam logic [1:0] CUSTOM_0 = 2'b00;
  localparam logic [1:0] CUSTOM_1 = 2'b01;
  localparam logic [1:0] CUSTOM_2 = 2'b10;
  localparam logic [1:0] CUSTOM_3 = 2'b11;

  localparam logic [3:0] FUNCT_ANDADD = 4'b0111;
  localparam logic [3:0] FUNCT_SUB    = 4'b0011;

  typedef struct packed {
    logic [5:0]      fn;
    logic [6:0]      imm;
    logic [XLEN-1:0] in1;
    logic [XLEN-1:0] in2;
  } ise_req_t;

  typedef struct packed {
    logic            err;
    logic [XLEN-1:0] data;
  } rfifo_ent_t;
endpackage

// File: rtl/csidh_ise_rfifo.sv
// Result FIFO of {err, data}; flush empties it at the clock edge and beats push/pop.
module csidh_ise_rfifo
  import csidh_ise_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       gclk,
  input  logic       grst_n,
  input  logic       flush,
  input  logic       push,
  input  rfifo_ent_t wdata,
  input  logic       pop,
  output rfifo_ent_t rdata,
  output logic       full,
  output logic       empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  rfifo_ent_t    mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic          do_push, do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign do_push = push && !flush;
  assign do_pop  = pop && !flush && !empty;
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: reads are masked to zero while empty.
  always_ff @(posedge gclk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/csidh_ise_ctrl.sv
// Issue/response controller: one issue register drives the external CSIDH
// datapath, results queue in a small FIFO so the core can stall writeback.
module csidh_ise_ctrl
  import csidh_ise_pkg::*;
#(
  parameter logic [1:0] ISE_V = 2'b11,
  parameter int         DEPTH = 2
) (
  input  logic            ise_clk,
  input  logic            ise_rst,
  input  logic            ise_flush,
  input  logic            ise_val,
  output logic            ise_rdy,
  input  logic [5:0]      ise_fn,
  input  logic [6:0]      ise_imm,
  input  logic [XLEN-1:0] ise_in1,
  input  logic [XLEN-1:0] ise_in2,
  output logic            ise_oval,
  input  logic            ise_ordy,
  output logic [XLEN-1:0] ise_out,
  output logic            ise_err,
  output logic            ise_busy,
  output logic [XLEN-1:0] dp_in1,
  output logic [XLEN-1:0] dp_in2,
  output logic [2:0]      dp_imm,
  output logic            dp_op_andadd,
  output logic            dp_op_sub,
  input  logic [XLEN-1:0] dp_rd
);
  ise_req_t   s1;
  logic       s1_v, s1_adv, pop, full, empty;
  logic       is_andadd, is_sub, legal, dp_en;
  logic       s1_unused;
  rfifo_ent_t push_ent, head;

  assign pop    = ise_oval && ise_ordy;
  assign s1_adv = s1_v && (!full || pop);
  // Reset is folded in so the core sees not-ready for the whole reset window.
  assign ise_rdy = ise_rst && !ise_flush && (!s1_v || s1_adv);

  always_ff @(posedge ise_clk or negedge ise_rst) begin
    if (!ise_rst) begin
      s1_v <= 1'b0;
      s1   <= '0;
    end else if (ise_flush) begin
      s1_v <= 1'b0;
    end else if (ise_val && ise_rdy) begin
      s1_v <= 1'b1;
      s1   <= '{fn: ise_fn, imm: ise_imm, in1: ise_in1, in2: ise_in2};
    end else if (s1_adv) begin
      s1_v <= 1'b0;
    end
  end

  assign s1_unused = ^s1.fn[5:2];

  assign is_andadd = ISE_V[1] && (s1.fn[1:0] == CUSTOM_0) && (s1.imm[3:0] == FUNCT_ANDADD);
  assign is_sub    = ISE_V[1] && (s1.fn[1:0] == CUSTOM_0) && (s1.imm[3:0] == FUNCT_SUB);
  assign legal     = is_andadd || is_sub;
  assign dp_en     = s1_v && legal;

  assign dp_in1       = dp_en ? s1.in1 : '0;
  assign dp_in2       = dp_en ? s1.in2 : '0;
  assign dp_imm       = dp_en ? s1.imm[6:4] : '0;
  assign dp_op_andadd = dp_en && is_andadd;
  assign dp_op_sub    = dp_en && is_sub;

  // Illegal ops still retire, carrying zero data and the error flag.
  assign push_ent.err  = !legal;
  assign push_ent.data = legal ? dp_rd : '0;

  csidh_ise_rfifo #(.DEPTH(DEPTH)) u_rfifo (
    .gclk   (ise_clk),
    .grst_n (ise_rst),
    .flush  (ise_flush),
    .push   (s1_adv),
    .wdata  (push_ent),
    .pop    (pop),
    .rdata  (head),
    .full   (full),
    .empty  (empty)
  );

  assign ise_oval = !empty;
  assign ise_out  = head.data;
  assign ise_err  = head.err;
  assign ise_busy = s1_v || !empty;
endmodule

// File: tb/tb_csidh_ise_ctrl.sv
// Scoreboard bench for csidh_ise_ctrl with a dp_rd = dp_in1 ^ dp_in2 datapath model.
module tb_csidh_ise_ctrl;
  logic        ise_clk = 1'b0;
  logic        ise_rst, ise_flush, ise_val, ise_ordy;
  logic        ise_rdy, ise_oval, ise_err, ise_busy;
  logic [5:0]  ise_fn;
  logic [6:0]  ise_imm;
  logic [63:0] ise_in1, ise_in2, ise_out;
  logic [63:0] dp_in1, dp_in2, dp_rd;
  logic [2:0]  dp_imm;
  logic        dp_op_andadd, dp_op_sub;

  typedef struct {
    logic [63:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   hs_cyc[$], pop_cyc[$];
  int   n_run = 0, n_fail = 0, cyc = 0, n_pop = 0, w = 0, acc = 0;

  csidh_ise_ctrl #(.ISE_V(2'b11), .DEPTH(2)) dut (
    .ise_clk(ise_clk), .ise_rst(ise_rst), .ise_flush(ise_flush),
    .ise_val(ise_val), .ise_rdy(ise_rdy), .ise_fn(ise_fn), .ise_imm(ise_imm),
    .ise_in1(ise_in1), .ise_in2(ise_in2), .ise_oval(ise_oval), .ise_ordy(ise_ordy),
    .ise_out(ise_out), .ise_err(ise_err), .ise_busy(ise_busy),
    .dp_in1(dp_in1), .dp_in2(dp_in2), .dp_imm(dp_imm),
    .dp_op_andadd(dp_op_andadd), .dp_op_sub(dp_op_sub), .dp_rd(dp_rd)
  );

  always #5 ise_clk = ~ise_clk;
  assign dp_rd = dp_in1 ^ dp_in2;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [5:0] fn, input logic [6:0] imm,
                                 input logic [63:0] a, input logic [63:0] b);
    exp_t e;
    logic lg;
    lg = (fn[1:0] == 2'b00) && (imm[3:0] == 4'b0111 || imm[3:0] == 4'b0011);
    e.data = lg ? (a ^ b) : 64'd0;
    e.err  = !lg;
    return e;
  endfunction

  always @(posedge ise_clk) cyc++;

  // Scoreboard: push on accepted request, pop/compare on accepted result.
  always @(negedge ise_clk) begin
    if (!ise_rst || ise_flush) begin
      sb.delete();
    end else begin
      if (ise_oval && ise_ordy) begin
        exp_t e;
        pop_cyc.push_back(cyc);
        n_pop++;
        if (sb.size() == 0) chk("stale_result", 64'd1, 64'd0);
        else begin
          e = sb.pop_front();
          chk("sb_out", ise_out, e.data);
          chk("sb_err", ise_err, e.err);
        end
      end
      if (ise_val && ise_rdy) begin
        hs_cyc.push_back(cyc);
        sb.push_back(model(ise_fn, ise_imm, ise_in1, ise_in2));
      end
    end
  end

  task automatic step();
    @(posedge ise_clk); #1;
  endtask

  task automatic smp();
    @(negedge ise_clk); #1;
  endtask

  task automatic send(input logic [5:0] fn, input logic [6:0] imm,
                      input logic [63:0] a, input logic [63:0] b, output int waits);
    waits = 0;
    ise_val = 1'b1; ise_fn = fn; ise_imm = imm; ise_in1 = a; ise_in2 = b;
    @(negedge ise_clk);
    while (!ise_rdy && waits < 50) begin
      @(negedge ise_clk);
      waits++;
    end
    if (!ise_rdy) chk("send_timeout", 64'd0, 64'd1);
    @(posedge ise_clk); #1;
    ise_val = 1'b0;
  endtask

  initial begin
    ise_rst = 1'b1; ise_flush = 1'b0; ise_val = 1'b0; ise_ordy = 1'b0;
    ise_fn = '0; ise_imm = '0; ise_in1 = '0; ise_in2 = '0;
    #1 ise_rst = 1'b0;
    #2;
    chk("rst_rdy", ise_rdy, 0);
    chk("rst_oval", ise_oval, 0);
    chk("rst_out", ise_out, 0);
    chk("rst_err", ise_err, 0);
    chk("rst_busy", ise_busy, 0);
    chk("rst_dp", {dp_in1 | dp_in2, dp_imm != 0, dp_op_andadd, dp_op_sub} != 0, 0);
    step(); step();
    ise_rst = 1'b1;
    smp();
    chk("rdy_after_rst", ise_rdy, 1);

    // single andadd op, latency 2
    ise_ordy = 1'b1;
    hs_cyc.delete(); pop_cyc.delete();
    step();
    send(6'h00, 7'b0010111, 64'hF0, 64'h0F, w);
    smp();
    chk("t1_andadd", dp_op_andadd, 1);
    chk("t1_sub", dp_op_sub, 0);
    chk("t1_imm", dp_imm, 3'b001);
    chk("t1_oval", ise_oval, 0);
    smp();
    chk("t2_oval", ise_oval, 1);
    chk("t2_out", ise_out, 64'hFF);
    chk("t2_err", ise_err, 0);
    smp();
    chk("single_lat", (pop_cyc.size() > 0 && hs_cyc.size() > 0) ? pop_cyc[0] - hs_cyc[0] : -1, 2);

    // 8 back-to-back subs
    hs_cyc.delete(); pop_cyc.delete(); n_pop = 0;
    step();
    for (int i = 0; i < 8; i++) begin
      send(6'h00, {i[2:0], 4'b0011}, 64'h1111 * (i + 1), 64'hA5 << i, w);
      chk("b2b_stall", w, 0);
    end
    repeat (5) smp();
    chk("b2b_n", n_pop, 8);
    if (pop_cyc.size() == 8 && hs_cyc.size() == 8) begin
      chk("b2b_consec", pop_cyc[7] - pop_cyc[0], 7);
      chk("b2b_lat", pop_cyc[0] - hs_cyc[0], 2);
    end

    // backpressure: 3 accepted with DEPTH=2
    ise_ordy = 1'b0; n_pop = 0; acc = 0;
    step();
    ise_val = 1'b1; ise_fn = 6'h00; ise_imm = 7'b0100111; ise_in1 = 64'd100; ise_in2 = 64'h3300;
    repeat (6) begin
      @(negedge ise_clk);
      if (ise_rdy) acc++;
      @(posedge ise_clk); #1;
      ise_in1 = 64'd100 + 64'(acc);
    end
    ise_val = 1'b0;
    chk("bp_acc", acc, 3);
    smp();
    chk("bp_rdy", ise_rdy, 0);
    chk("bp_busy", ise_busy, 1);
    step();
    ise_ordy = 1'b1;
    repeat (5) smp();
    chk("bp_drain", n_pop, 3);
    chk("bp_rdy_back", ise_rdy, 1);

    // illegal ops
    step();
    send(6'h01, 7'b0000111, 64'h1234, 64'h5678, w);
    smp();
    chk("ill_busy", ise_busy, 1);
    chk("ill_dp", {dp_in1 | dp_in2, dp_imm != 0, dp_op_andadd, dp_op_sub} != 0, 0);
    smp();
    chk("ill_oval", ise_oval, 1);
    chk("ill_err", ise_err, 1);
    chk("ill_out", ise_out, 0);
    step();
    send(6'h00, 7'b1110001, 64'hDEAD, 64'hBEEF, w);
    repeat (3) smp();

    // flush with FIFO full and S1 valid
    ise_ordy = 1'b0;
    step();
    for (int i = 0; i < 3; i++) send(6'h00, 7'b0000011, 64'(i + 7), 64'h1, w);
    ise_flush = 1'b1; ise_val = 1'b1;
    smp();
    chk("fl_rdy", ise_rdy, 0);
    step();
    ise_flush = 1'b0; ise_val = 1'b0;
    smp();
    chk("fl_oval", ise_oval, 0);
    chk("fl_busy", ise_busy, 0);
    ise_ordy = 1'b1; n_pop = 0;
    repeat (4) smp();
    chk("fl_stale", n_pop, 0);

    // asynchronous reset mid-stream
    ise_ordy = 1'b0;
    step();
    send(6'h00, 7'b0000111, 64'h55, 64'hAA, w);
    send(6'h00, 7'b0000011, 64'h66, 64'h99, w);
    @(negedge ise_clk); #1;
    ise_rst = 1'b0;
    #1;
    chk("ar_oval", ise_oval, 0);
    chk("ar_out", ise_out, 0);
    chk("ar_busy", ise_busy, 0);
    chk("ar_rdy", ise_rdy, 0);
    chk("ar_dp", {dp_in1 | dp_in2, dp_imm != 0, dp_op_andadd, dp_op_sub} != 0, 0);
    step(); step();
    ise_rst = 1'b1;
    ise_ordy = 1'b1; n_pop = 0;
    hs_cyc.delete(); pop_cyc.delete();
    send(6'h00, 7'b0110011, 64'hC0DE, 64'h0F0F, w);
    repeat (3) smp();
    chk("ar_npop", n_pop, 1);
    chk("ar_lat", (pop_cyc.size() > 0 && hs_cyc.size() > 0) ? pop_cyc[0] - hs_cyc[0] : -1, 2);
    chk("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
